// File: rtl/pipe_pkg.sv
// Shared types and constants for the 16-bit, 8-register, 5-stage pipeline.
// Used by fetch, decode and the hazard unit.
package pipe_pkg;

  localparam int              WIDTH     = 16;
  localparam logic [15:0]     RESET_PC  = 16'h0000;
  localparam logic [15:0]     NOP_INSTR = 16'h0800;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    ERR    = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [WIDTH-1:0] instr;
    logic [WIDTH-1:0] pc2;
    logic             valid;
  } ifid_t;

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: load-enable, bubble insertion (bubble wins), async reset.
// A bubble leaves pc2 untouched; only instr and valid carry meaning for a bubble.
module ifid_reg #(
  parameter int               WIDTH     = pipe_pkg::WIDTH,
  parameter logic [WIDTH-1:0] NOP_INSTR = pipe_pkg::NOP_INSTR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             bubble,
  input  logic [WIDTH-1:0] in_instr,
  input  logic [WIDTH-1:0] in_pc2,
  output logic [WIDTH-1:0] instr_q,
  output logic [WIDTH-1:0] pc2_q,
  output logic             valid_q
);

  logic [WIDTH-1:0] instr_d;
  logic [WIDTH-1:0] pc2_d;
  logic             valid_d;

  // Next-value selection for the IF/ID contents.
  always_comb begin
    instr_d = instr_q;
    pc2_d   = pc2_q;
    valid_d = valid_q;
    if (bubble) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (load) begin
      instr_d = in_instr;
      pc2_d   = in_pc2;
      valid_d = 1'b1;
    end else begin
      instr_d = instr_q;
      pc2_d   = pc2_q;
      valid_d = valid_q;
    end
  end

  // IF/ID storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= NOP_INSTR;
      pc2_q   <= {WIDTH{1'b0}};
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc2_q   <= pc2_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC and the RUN/HALTED/ERR fetch FSM,
// feeds the IF/ID register, honours hazard freezes, EX redirects and imem stalls.
module fetch_stage
  import pipe_pkg::fetch_state_e;
  import pipe_pkg::RUN;
  import pipe_pkg::HALTED;
  import pipe_pkg::ERR;
#(
  parameter int               WIDTH     = pipe_pkg::WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC  = pipe_pkg::RESET_PC,
  parameter logic [WIDTH-1:0] NOP_INSTR = pipe_pkg::NOP_INSTR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pcWrite,
  input  logic             ifid_write,
  input  logic             flush,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             halt_dec,
  input  logic [WIDTH-1:0] imem_instr,
  input  logic             imem_busy,
  output logic [WIDTH-1:0] imem_addr,
  output logic             imem_rd,
  output logic [WIDTH-1:0] ifid_instr,
  output logic [WIDTH-1:0] ifid_pc2,
  output logic             ifid_valid,
  output logic             halted,
  output logic             fetch_err
);

  fetch_state_e     state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             halted_q, halted_d;
  logic             err_q, err_d;
  logic             ifid_load_s;
  logic             ifid_bubble_s;
  logic [WIDTH-1:0] pc_plus2_s;

  assign pc_plus2_s = pc_q + WIDTH'(2'd2);
  assign imem_addr  = pc_q;
  assign imem_rd    = (state_q == RUN) && !rst;
  assign halted     = halted_q;
  assign fetch_err  = err_q;

  // Next-state and PC/IF-ID control, evaluated in priority order.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    halted_d      = halted_q;
    err_d         = err_q;
    ifid_load_s   = 1'b0;
    ifid_bubble_s = 1'b0;
    case (state_q)
      RUN, HALTED: begin
        if (flush && redirect_pc[0]) begin
          state_d       = ERR;
          err_d         = 1'b1;
          ifid_bubble_s = 1'b1;
        end else if (flush) begin
          // Redirect also cancels a HALT that was fetched on a wrong path.
          state_d       = RUN;
          pc_d          = redirect_pc;
          halted_d      = 1'b0;
          ifid_bubble_s = 1'b1;
        end else if (state_q == RUN) begin
          if (halt_dec && ifid_valid) begin
            state_d       = HALTED;
            halted_d      = 1'b1;
            ifid_bubble_s = 1'b1;
          end else if (!ifid_write) begin
            pc_d = pc_q;
          end else if (imem_busy) begin
            ifid_bubble_s = 1'b1;
          end else begin
            ifid_load_s = 1'b1;
            pc_d        = pcWrite ? pc_plus2_s : pc_q;
          end
        end else begin
          pc_d = pc_q;
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d       = ERR;
        err_d         = 1'b1;
        ifid_bubble_s = 1'b1;
      end
    endcase
  end

  // PC, FSM state and sticky status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
      err_q    <= err_d;
    end
  end

  ifid_reg #(
    .WIDTH     (WIDTH),
    .NOP_INSTR (NOP_INSTR)
  ) u_ifid_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (ifid_load_s),
    .bubble   (ifid_bubble_s),
    .in_instr (imem_instr),
    .in_pc2   (pc_plus2_s),
    .instr_q  (ifid_instr),
    .pc2_q    (ifid_pc2),
    .valid_q  (ifid_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Table-driven bench for fetch_stage: per-cycle stimulus records with hand-derived
// expectations queued as a scoreboard, plus asynchronous-reset sequences.
module tb_fetch_stage;

  localparam logic [15:0] NOP = 16'h0800;

  logic        clk = 1'b0;
  logic        rst;
  logic        pcWrite, ifid_write, flush, halt_dec, imem_busy;
  logic [15:0] redirect_pc, imem_instr;
  logic [15:0] imem_addr, ifid_instr, ifid_pc2;
  logic        imem_rd, ifid_valid, halted, fetch_err;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        flush;
    logic [15:0] rpc;
    logic        pcw;
    logic        ifw;
    logic        busy;
    logic        hd;
    logic [15:0] instr;
    logic [15:0] e_addr;
    logic [15:0] e_instr;
    logic [15:0] e_pc2;
    logic        e_valid;
    logic        e_halted;
    logic        e_err;
    logic        e_rd;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .pcWrite     (pcWrite),
    .ifid_write  (ifid_write),
    .flush       (flush),
    .redirect_pc (redirect_pc),
    .halt_dec    (halt_dec),
    .imem_instr  (imem_instr),
    .imem_busy   (imem_busy),
    .imem_addr   (imem_addr),
    .imem_rd     (imem_rd),
    .ifid_instr  (ifid_instr),
    .ifid_pc2    (ifid_pc2),
    .ifid_valid  (ifid_valid),
    .halted      (halted),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Build a record: stimulus fields, then expected outputs after the clock edge.
  function automatic vec_t mk(input logic fl, input logic [15:0] rpc, input logic pcw,
                              input logic ifw, input logic busy, input logic hd,
                              input logic [15:0] ins, input logic [15:0] ea,
                              input logic [15:0] ei, input logic [15:0] ep,
                              input logic ev, input logic eh, input logic ee, input logic er);
    vec_t v;
    v.flush = fl; v.rpc = rpc; v.pcw = pcw; v.ifw = ifw; v.busy = busy; v.hd = hd;
    v.instr = ins; v.e_addr = ea; v.e_instr = ei; v.e_pc2 = ep; v.e_valid = ev;
    v.e_halted = eh; v.e_err = ee; v.e_rd = er;
    return v;
  endfunction

  function automatic vec_t norm(input logic [15:0] ins, input logic [15:0] ea, input logic [15:0] ep);
    return mk(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, ins, ea, ins, ep, 1'b1, 1'b0, 1'b0, 1'b1);
  endfunction

  function automatic vec_t redir(input logic [15:0] tgt);
    return mk(1'b1, tgt, 1'b1, 1'b1, 1'b0, 1'b0, 16'h1111, tgt, NOP, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
  endfunction

  task automatic drive(input vec_t v);
    flush = v.flush; redirect_pc = v.rpc; pcWrite = v.pcw; ifid_write = v.ifw;
    imem_busy = v.busy; halt_dec = v.hd; imem_instr = v.instr;
  endtask

  task automatic compare(input vec_t e, input string tag);
    chk({tag, " imem_addr"}, imem_addr, e.e_addr);
    chk({tag, " ifid_instr"}, ifid_instr, e.e_instr);
    chk({tag, " ifid_valid"}, {15'd0, ifid_valid}, {15'd0, e.e_valid});
    if (e.e_valid) chk({tag, " ifid_pc2"}, ifid_pc2, e.e_pc2);
    chk({tag, " halted"}, {15'd0, halted}, {15'd0, e.e_halted});
    chk({tag, " fetch_err"}, {15'd0, fetch_err}, {15'd0, e.e_err});
    chk({tag, " imem_rd"}, {15'd0, imem_rd}, {15'd0, e.e_rd});
  endtask

  initial begin
    vec_t e;
    rst = 1'b1;
    drive(mk(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000,
             16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0));

    // Straight-line fetch from reset.
    vecs.push_back(norm(16'h4001, 16'h0002, 16'h0002));
    vecs.push_back(norm(16'h4002, 16'h0004, 16'h0004));
    vecs.push_back(norm(16'h4003, 16'h0006, 16'h0006));
    vecs.push_back(norm(16'h4004, 16'h0008, 16'h0008));
    // Reach 0x0010 with a valid instruction in IF/ID, then freeze two cycles.
    vecs.push_back(redir(16'h000E));
    vecs.push_back(norm(16'h4005, 16'h0010, 16'h0010));
    for (int i = 0; i < 2; i++)
      vecs.push_back(mk(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h5555,
                        16'h0010, 16'h4005, 16'h0010, 1'b1, 1'b0, 1'b0, 1'b1));
    vecs.push_back(norm(16'h4006, 16'h0012, 16'h0012));
    // Flush during a freeze wins over pcWrite/ifid_write = 0.
    vecs.push_back(mk(1'b1, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0, 16'h5555,
                      16'h0100, NOP, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(norm(16'h4007, 16'h0102, 16'h0102));
    // Memory busy for three cycles at 0x0020.
    vecs.push_back(redir(16'h0020));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1'b0, 16'h0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h6666,
                        16'h0020, NOP, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(norm(16'h4008, 16'h0022, 16'h0022));
    // HALT decoded on a valid instruction, then ten idle cycles.
    vecs.push_back(mk(1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h7777,
                      16'h0022, NOP, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0));
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk(1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h7777,
                        16'h0022, NOP, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(redir(16'h0040));
    vecs.push_back(norm(16'h4009, 16'h0042, 16'h0042));
    // PC wrap at the top of the address space.
    vecs.push_back(redir(16'hFFFE));
    vecs.push_back(norm(16'h400A, 16'h0000, 16'h0000));
    // Misaligned redirect, then an ignored aligned flush and ignored fetch cycles.
    vecs.push_back(mk(1'b1, 16'h0031, 1'b1, 1'b1, 1'b0, 1'b0, 16'h1111,
                      16'h0000, NOP, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 16'h0050, 1'b1, 1'b1, 1'b0, 1'b0, 16'h1111,
                      16'h0000, NOP, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0));
    for (int i = 0; i < 2; i++)
      vecs.push_back(mk(1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h4444,
                        16'h0000, NOP, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0));

    // Reset state while rst is held.
    repeat (2) @(posedge clk);
    @(negedge clk);
    compare(mk(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0,
               16'h0000, NOP, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0), "reset");
    rst = 1'b0;
    #1;
    chk("release addr", imem_addr, 16'h0000);
    chk("release rd", {15'd0, imem_rd}, 16'h0001);

    foreach (vecs[k]) begin
      if (k != 0) @(negedge clk);
      drive(vecs[k]);
      sb.push_back(vecs[k]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      compare(e, $sformatf("vec%0d", k));
    end

    // Asynchronous reset out of ERR, no clock edge in between.
    @(negedge clk);
    rst = 1'b1;
    #1;
    compare(mk(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0,
               16'h0000, NOP, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0), "async_rst_err");
    @(negedge clk);
    rst = 1'b0;
    drive(norm(16'h400B, 16'h0, 16'h0));
    #1;
    chk("post_rst addr", imem_addr, 16'h0000);
    @(posedge clk);
    #1;
    compare(norm(16'h400B, 16'h0002, 16'h0002), "post_rst fetch");

    // Asynchronous reset mid-stream while running.
    @(negedge clk);
    drive(norm(16'h400C, 16'h0, 16'h0));
    #2;
    rst = 1'b1;
    #1;
    compare(mk(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0,
               16'h0000, NOP, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0), "async_rst_run");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    compare(norm(16'h400C, 16'h0002, 16'h0002), "rerun fetch");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
